// File: rtl/la_ctrl_pkg.sv
// Shared constants and payload types for the logic-analyzer front-panel control blocks.
// Default timing assumes a 25 MHz clock: 10 ms debounce, 500 ms hold, 100 ms repeat.
package la_ctrl_pkg;

    localparam int unsigned DEB_CYC_DEF  = 250000;
    localparam int unsigned HOLD_CYC_DEF = 12500000;
    localparam int unsigned RPT_CYC_DEF  = 2500000;

    localparam int unsigned SEL_W_DEF  = 2;
    localparam int unsigned ZOOM_W_DEF = 2;
    localparam int unsigned OFS_W_DEF  = 2;

    // One event bit per front-panel button; ofs_inc is bit 0 (SW1) through clk_next bit 4 (SW5)
    typedef struct packed {
        logic clk_next;
        logic zoom_out;
        logic zoom_in;
        logic ofs_dec;
        logic ofs_inc;
    } btn_evt_t;

endpackage

// File: rtl/btn_conditioner.sv
// Synchroniser, debounce, press-edge detect and optional auto-repeat for one raw button.
// evt is a registered one-cycle pulse per press (and per repeat when REPEAT_EN is set).
module btn_conditioner
    import la_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYC   = DEB_CYC_DEF,
    parameter int unsigned HOLD_CYC  = HOLD_CYC_DEF,
    parameter int unsigned RPT_CYC   = RPT_CYC_DEF,
    parameter bit          REPEAT_EN = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic evt
);

    localparam int unsigned DEB_W  = $clog2(DEB_CYC);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);

    logic              sync1_q, sync2_q;
    logic              deb_q, deb_d, deb_dly_q;
    logic [DEB_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              rpt_fire;
    logic              evt_q, evt_d;

    // Debounce: adopt the synchronised level after DEB_CYC consecutive differing cycles
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == DEB_W'(DEB_CYC - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + DEB_W'(1);
            end
        end
    end

    // Hold counter reloads so that it reaches HOLD_CYC again every RPT_CYC cycles
    always_comb begin
        hold_d   = '0;
        rpt_fire = 1'b0;
        if (REPEAT_EN && deb_q) begin
            if (hold_q == HOLD_W'(HOLD_CYC)) begin
                rpt_fire = 1'b1;
                hold_d   = HOLD_W'(HOLD_CYC - RPT_CYC + 1);
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
        evt_d = (deb_q & ~deb_dly_q) | rpt_fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            cnt_q     <= '0;
            hold_q    <= '0;
            evt_q     <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            evt_q     <= evt_d;
        end
    end

    assign evt = evt_q;

endmodule

// File: rtl/vga_view_ctrl.sv
// Front-panel controller for the logic-analyzer VGA view: sample-clock select, zoom and offset
// registers driven by five conditioned buttons, plus a one-cycle view-change pulse.
module vga_view_ctrl
    import la_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYC  = DEB_CYC_DEF,
    parameter int unsigned HOLD_CYC = HOLD_CYC_DEF,
    parameter int unsigned RPT_CYC  = RPT_CYC_DEF,
    parameter int unsigned SEL_W    = SEL_W_DEF,
    parameter int unsigned ZOOM_W   = ZOOM_W_DEF,
    parameter int unsigned OFS_W    = OFS_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    SW1,
    input  logic                    SW2,
    input  logic                    SW3,
    input  logic                    SW4,
    input  logic                    SW5,
    output logic [SEL_W-1:0]        smpl_clk_sel,
    output logic [(1 << SEL_W)-1:0] LED,
    output logic [ZOOM_W-1:0]       zoom,
    output logic [OFS_W-1:0]        offset,
    output logic                    view_chg
);

    localparam int unsigned LED_W = 1 << SEL_W;
    localparam logic [ZOOM_W-1:0] ZOOM_MAX = '1;
    localparam logic [OFS_W-1:0]  OFS_MAX  = '1;

    logic [4:0] sw_raw;
    logic [4:0] evt_vec;
    btn_evt_t   evt;

    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [ZOOM_W-1:0] zoom_q, zoom_d;
    logic [OFS_W-1:0]  ofs_q, ofs_d;
    logic              view_chg_q, view_chg_d;

    assign sw_raw = {SW5, SW4, SW3, SW2, SW1};

    // Only the offset buttons (SW1/SW2) auto-repeat
    for (genvar gi = 0; gi < 5; gi++) begin : g_btn
        btn_conditioner #(
            .DEB_CYC  (DEB_CYC),
            .HOLD_CYC (HOLD_CYC),
            .RPT_CYC  (RPT_CYC),
            .REPEAT_EN(1'(gi < 2))
        ) u_btn (
            .clk    (clk),
            .rst_n  (reset),
            .btn_raw(sw_raw[gi]),
            .evt    (evt_vec[gi])
        );
    end

    assign evt = btn_evt_t'(evt_vec);

    // Saturating zoom/offset, wrapping sample-clock select; a zoom change recentres the offset
    always_comb begin
        sel_d  = sel_q;
        zoom_d = zoom_q;
        ofs_d  = ofs_q;
        if (evt.clk_next) begin
            sel_d = sel_q + SEL_W'(1);
        end
        if (evt.zoom_in && !evt.zoom_out && zoom_q != ZOOM_MAX) begin
            zoom_d = zoom_q + ZOOM_W'(1);
        end else if (evt.zoom_out && !evt.zoom_in && zoom_q != '0) begin
            zoom_d = zoom_q - ZOOM_W'(1);
        end
        if (evt.ofs_inc && !evt.ofs_dec && ofs_q != OFS_MAX) begin
            ofs_d = ofs_q + OFS_W'(1);
        end else if (evt.ofs_dec && !evt.ofs_inc && ofs_q != '0) begin
            ofs_d = ofs_q - OFS_W'(1);
        end
        if (zoom_d != zoom_q) begin
            ofs_d = '0;
        end
        view_chg_d = (sel_d != sel_q) || (zoom_d != zoom_q) || (ofs_d != ofs_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q      <= '0;
            zoom_q     <= '0;
            ofs_q      <= '0;
            view_chg_q <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            zoom_q     <= zoom_d;
            ofs_q      <= ofs_d;
            view_chg_q <= view_chg_d;
        end
    end

    assign smpl_clk_sel = sel_q;
    assign zoom         = zoom_q;
    assign offset       = ofs_q;
    assign view_chg     = view_chg_q;
    assign LED          = LED_W'(1) << sel_q;

endmodule

// File: tb/tb_vga_view_ctrl.sv
// Directed and random stimulus for vga_view_ctrl, checked each cycle against an edge-indexed
// model built from the documented debounce/press/repeat timing.
module tb_vga_view_ctrl;

    localparam int D    = 4;
    localparam int H    = 16;
    localparam int R    = 4;
    localparam int MAXN = 4096;

    logic       clk = 1'b0;
    logic       reset;
    logic       sw1, sw2, sw3, sw4, sw5;
    logic [1:0] smpl_clk_sel;
    logic [3:0] led;
    logic [1:0] zoom;
    logic [1:0] offset;
    logic       view_chg;

    always #5 clk = ~clk;

    vga_view_ctrl #(
        .DEB_CYC (D),
        .HOLD_CYC(H),
        .RPT_CYC (R),
        .SEL_W   (2),
        .ZOOM_W  (2),
        .OFS_W   (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .SW1         (sw1),
        .SW2         (sw2),
        .SW3         (sw3),
        .SW4         (sw4),
        .SW5         (sw5),
        .smpl_clk_sel(smpl_clk_sel),
        .LED         (led),
        .zoom        (zoom),
        .offset      (offset),
        .view_chg    (view_chg)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: raw samples and debounced level per button, indexed by edge number since reset
    bit samp [5][MAXN];
    bit debh [5][MAXN];
    int rise [5];
    int n;
    int m_sel, m_zoom, m_ofs;
    bit m_chg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, n);
        end
    endtask

    function automatic bit get_samp(int b, int k);
        return (k < 0) ? 1'b0 : samp[b][k];
    endfunction

    task automatic model_reset();
        n      = 0;
        m_sel  = 0;
        m_zoom = 0;
        m_ofs  = 0;
        m_chg  = 1'b0;
        for (int b = 0; b < 5; b++) rise[b] = 0;
    endtask

    // One clock edge: raw is the input level sampled at this edge
    task automatic model_edge(input logic [4:0] raw);
        logic [4:0] ev;
        bit prev, flip, cur;
        int d, nz, no, ns;
        for (int b = 0; b < 5; b++) begin
            prev       = (n > 0) ? debh[b][n-1] : 1'b0;
            samp[b][n] = raw[b];
            // output change at edge n follows a debounced rise at n-2, or a held repeat slot
            ev[b] = 1'b0;
            if (n >= 2 && debh[b][n-2]) begin
                d     = n - 2 - rise[b];
                ev[b] = (d == 0) || (b < 2 && d >= H && ((d - H) % R) == 0);
            end
            // level is seen two edges late; it flips after D consecutive differing samples
            flip = 1'b1;
            for (int k = n - D - 1; k <= n - 2; k++) begin
                if (get_samp(b, k) == prev) flip = 1'b0;
            end
            cur        = flip ? ~prev : prev;
            debh[b][n] = cur;
            if (cur && !prev) rise[b] = n;
        end
        nz = m_zoom;
        if (ev[2] && !ev[3]) nz = (m_zoom < 3) ? m_zoom + 1 : m_zoom;
        else if (ev[3] && !ev[2]) nz = (m_zoom > 0) ? m_zoom - 1 : m_zoom;
        no = m_ofs;
        if (ev[0] && !ev[1]) no = (m_ofs < 3) ? m_ofs + 1 : m_ofs;
        else if (ev[1] && !ev[0]) no = (m_ofs > 0) ? m_ofs - 1 : m_ofs;
        if (nz != m_zoom) no = 0;
        ns = ev[4] ? (m_sel + 1) % 4 : m_sel;
        m_chg  = (ns != m_sel) || (nz != m_zoom) || (no != m_ofs);
        m_sel  = ns;
        m_zoom = nz;
        m_ofs  = no;
        n++;
    endtask

    task automatic cycle(input logic [4:0] raw);
        {sw5, sw4, sw3, sw2, sw1} = raw;
        @(posedge clk);
        model_edge(raw);
        #1;
        chk("sel", smpl_clk_sel, m_sel);
        chk("led", led, 32'(1) << m_sel);
        chk("zoom", zoom, m_zoom);
        chk("offset", offset, m_ofs);
        chk("view_chg", view_chg, m_chg);
    endtask

    task automatic hold(input logic [4:0] raw, input int cyc);
        for (int i = 0; i < cyc; i++) cycle(raw);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sel"}, smpl_clk_sel, 0);
        chk({tag, "_led"}, led, 4'b0001);
        chk({tag, "_zoom"}, zoom, 0);
        chk({tag, "_offset"}, offset, 0);
        chk({tag, "_view_chg"}, view_chg, 0);
    endtask

    initial begin
        logic [4:0] rnd;
        reset = 1'b0;
        {sw5, sw4, sw3, sw2, sw1} = 5'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        reset = 1'b1;
        model_reset();
        hold(5'b00000, 4);
        chk_reset_vals("idle");

        // Five clean sample-clock presses
        for (int i = 0; i < 5; i++) begin
            hold(5'b10000, D + 5);
            hold(5'b00000, D + 5);
            chk("sel_step", smpl_clk_sel, (i + 1) % 4);
        end

        // Bouncing SW1 never settles long enough
        for (int i = 0; i < 5; i++) begin
            hold(5'b00001, 2);
            hold(5'b00000, 2);
        end
        hold(5'b00001, 3);
        hold(5'b00000, D + 4);
        chk("bounce_offset", offset, 0);

        // SW1 held: press, then repeats until saturation
        hold(5'b00001, 40);
        chk("hold_offset", offset, 3);
        hold(5'b00000, D + 4);

        // Down to 2, then zoom in clears offset, then zoom out twice (second saturates)
        hold(5'b00010, D + 4);
        hold(5'b00000, D + 4);
        chk("dec_offset", offset, 2);
        hold(5'b00100, D + 4);
        hold(5'b00000, D + 4);
        chk("zoom_in_zoom", zoom, 1);
        chk("zoom_in_offset", offset, 0);
        for (int i = 0; i < 2; i++) begin
            hold(5'b01000, D + 4);
            hold(5'b00000, D + 4);
            chk("zoom_out_zoom", zoom, 0);
        end

        // Simultaneous SW1/SW2 leaves offset alone
        hold(5'b00001, D + 4);
        hold(5'b00000, D + 4);
        hold(5'b00011, D + 4);
        hold(5'b00000, D + 4);
        chk("both_offset", offset, 1);

        // Reset while SW1 is held, button must debounce again afterwards
        hold(5'b00001, D + 6);
        reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        hold(5'b00001, D + 3);
        chk("post_rst_wait", offset, 0);
        hold(5'b00001, 1);
        chk("post_rst_offset", offset, 1);
        chk("post_rst_chg", view_chg, 1);
        hold(5'b00000, D + 4);

        // Random levels with sticky holds, covering bounce, repeats and overlaps
        rnd = 5'b0;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(0, 9) == 0) rnd[b] = ~rnd[b];
            end
            cycle(rnd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
